seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_ctrl                                                |
// | Description : 4-digit multiplexed 7-segment scanner with frame-committed   |
// |               double-buffered display data and leading-zero blanking.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int DIV      = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [15:0] c_CNT_MAX = 16'(DIV - 1);
  localparam logic [1:0]  c_LAST    = 2'd3;

  logic [15:0] r_cnt;
  logic [1:0]  r_sel;
  logic        r_frame_done;
  logic [15:0] r_pend_val;
  logic [3:0]  r_pend_dp;
  logic        r_pend_v;
  logic [15:0] r_disp_val;
  logic [3:0]  r_disp_dp;

  logic        w_tick;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic [6:0]  w_hex_seg;
  logic        w_lz_blank;

  assign w_tick = (r_cnt == c_CNT_MAX);
  assign w_wrap = w_tick && (r_sel == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_sel        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_cnt <= '0;
        r_sel <= r_sel + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // A load coinciding with the wrap bypasses the pending buffer so it is
  // shown in the very next frame and leaves nothing pending behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pend_v   <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else if (w_wrap) begin
      if (load) begin
        r_disp_val <= value;
        r_disp_dp  <= dp_in;
      end else if (r_pend_v) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      r_pend_v <= 1'b0;
    end else if (load) begin
      r_pend_val <= value;
      r_pend_dp  <= dp_in;
      r_pend_v   <= 1'b1;
    end
  end

  always_comb begin
    w_nib      = r_disp_val[3:0];
    w_lz_blank = 1'b0;
    case (r_sel)
      2'd1: begin
        w_nib      = r_disp_val[7:4];
        w_lz_blank = (r_disp_val[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib      = r_disp_val[11:8];
        w_lz_blank = (r_disp_val[15:8] == 8'h00);
      end
      2'd3: begin
        w_nib      = r_disp_val[15:12];
        w_lz_blank = (r_disp_val[15:12] == 4'h0);
      end
      default: begin
        w_nib      = r_disp_val[3:0];
        w_lz_blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_hex_seg = 7'h00;
    case (w_nib)
      4'h0: w_hex_seg = 7'h3F;
      4'h1: w_hex_seg = 7'h06;
      4'h2: w_hex_seg = 7'h5B;
      4'h3: w_hex_seg = 7'h4F;
      4'h4: w_hex_seg = 7'h66;
      4'h5: w_hex_seg = 7'h6D;
      4'h6: w_hex_seg = 7'h7D;
      4'h7: w_hex_seg = 7'h07;
      4'h8: w_hex_seg = 7'h7F;
      4'h9: w_hex_seg = 7'h6F;
      4'hA: w_hex_seg = 7'h77;
      4'hB: w_hex_seg = 7'h7C;
      4'hC: w_hex_seg = 7'h39;
      4'hD: w_hex_seg = 7'h5E;
      4'hE: w_hex_seg = 7'h79;
      4'hF: w_hex_seg = 7'h71;
      default: w_hex_seg = 7'h00;
    endcase
  end

  assign seg        = (BLANK_LZ && w_lz_blank) ? 7'h00 : w_hex_seg;
  assign dp         = r_disp_dp[r_sel];
  assign digit_sel  = r_sel;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
